serial_rx_controller: RTL and testbench
=======================================

Name: serial_rx_controller

Overview:
- Oversampling UART-style receive controller: generates the sample tick from the system clock and sequences start-bit validation, data-bit capture and stop-bit check.
- Delivers each received byte to the host side over a valid/ready handshake, with framing-error and overrun reporting.
- Sits between the raw serial line (din) and the transceiver's byte-level logic; it replaces free-running sampling with a fully sequenced, resettable receive path.

Parameters:
- CLK_DIV, 325: clk cycles per sample tick, >=2 (50 MHz / (9600*16) ~ 325).
- SAMPLE_RATIO, 16: sample ticks per bit period; even, 4..16.
- DATA_BITS, 8: data bits per frame, 5..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  received byte, LSB = first bit on line.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  one-clk pulse: byte dropped because rx_valid was still pending.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, all counters 0, sync flops = 1, shift reg 0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0. Reset mid-frame abandons the frame; no output pulse results.
- din passes through a 2-flop synchronizer (din_s); FSM uses din_s only.
- Tick divider: free-running 0..CLK_DIV-1, wraps; tick=1 for one clk when count==CLK_DIV-1. All FSM advances occur only on tick cycles.
- States: IDLE, START, DATA, STOP, WAIT_IDLE (also PARITY with the feature below).
  - IDLE: on tick with din_s==0 -> START, scount=0.
  - START: scount++ per tick; at scount==SAMPLE_RATIO/2-1: din_s==0 -> DATA, scount=0, bitcnt=0; din_s==1 -> IDLE (glitch rejected, no output).
  - DATA: scount++ per tick; at scount==SAMPLE_RATIO-1: shift din_s into MSB of shift reg (right shift), scount=0, bitcnt++; after bit DATA_BITS-1 -> STOP.
  - STOP: at scount==SAMPLE_RATIO-1: din_s==1 -> deliver byte, go IDLE; din_s==0 -> frame_err=1 for that clk, byte discarded, go WAIT_IDLE.
  - WAIT_IDLE: stay until a tick with din_s==1, then IDLE. Prevents a break condition from being taken as back-to-back starts.
- Delivery, on the clk edge that samples the stop bit:
  - rx_valid==0, or rx_valid&&rx_ready in the same cycle: rx_data<=shift, rx_valid<=1.
  - rx_valid==1 && rx_ready==0: new byte dropped, rx_data unchanged, overrun=1 for one clk.
- Handshake: rx_valid holds, and rx_data stays stable, until a cycle with rx_ready=1; rx_valid clears on the following edge unless a new byte loads on that same edge. rx_ready while rx_valid=0 is ignored.
- frame_err and overrun are never asserted together; both are registered outputs.
- Counter widths: scount is wide enough for SAMPLE_RATIO-1; bitcnt holds 0..DATA_BITS.

Optional Feature:
- Macro SERIAL_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even parity) and output port parity_err (1 bit).
  - After the last data bit: DATA -> PARITY; one bit period sampled at scount==SAMPLE_RATIO-1, then -> STOP.
  - At the stop sample, a parity mismatch with a good stop bit: byte discarded, parity_err=1 for one clk, no rx_valid/overrun change.
  - Stop bit low: frame_err takes priority and parity_err stays 0.
- Undefined: no PARITY state, no parity_err port; frame = start + DATA_BITS + stop.

Test Plan:
- CLK_DIV=4, SAMPLE_RATIO=16 (bit = 64 clk), rx_ready=1; send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> rx_valid 1 clk with rx_data=0xA5, frame_err=0, busy drops to 0.
- din low for 16 clk (4 ticks) then high -> returns to IDLE, no rx_valid/frame_err; busy pulses only.
- Send 0x3C with stop bit 0, hold din low 200 clk, then high -> frame_err single pulse, no rx_valid; busy stays 1 until din_s high observed on a tick.
- rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_valid=1 with rx_data=0x11; at 0x22 stop sample overrun pulses once, rx_data stays 0x11. Then rx_ready=1 -> rx_valid clears next edge.
- rst_n low for 3 clk midway through data bit 4 of 0x5A, then send 0x81 -> only 0x81 delivered, no error pulses.
- SERIAL_RX_PARITY_EN, even parity: 0x07 with parity bit 1 -> rx_data=0x07 delivered; 0x07 with parity bit 0 -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/serial_rx_controller.sv
// Oversampling UART-style receiver: tick divider, start/data/stop sequencing, valid/ready byte delivery.
// Optional even/odd parity bit and parity_err output when SERIAL_RX_PARITY_EN is defined.
module serial_rx_controller #(
    parameter int CLK_DIV      = 325,
    parameter int SAMPLE_RATIO = 16,
    parameter int DATA_BITS    = 8
`ifdef SERIAL_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int SC_W  = $clog2(SAMPLE_RATIO);
    localparam int BC_W  = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(SAMPLE_RATIO / 2 - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SAMPLE_RATIO - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
`ifdef SERIAL_RX_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t               state;
    logic                 din_meta;
    logic                 din_s;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    logic [SC_W-1:0]      scount;
    logic [BC_W-1:0]      bitcnt;
    logic [DATA_BITS-1:0] shift;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_bit;

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        return ((^d) ^ p) != PARITY_ODD;
    endfunction
`endif

    assign tick = (div_cnt == DIV_LAST);
    assign busy = (state != IDLE);

    // din is asynchronous to clk; only the second flop feeds the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta <= 1'b1;
            din_s    <= 1'b1;
            div_cnt  <= '0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            scount    <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!din_s) begin
                            state  <= START;
                            scount <= '0;
                        end
                    end
                    START: begin
                        if (scount == SC_HALF) begin
                            scount <= '0;
                            bitcnt <= '0;
                            state  <= din_s ? IDLE : DATA;
                        end else begin
                            scount <= scount + 1'b1;
                        end
                    end
                    DATA: begin
                        if (scount == SC_LAST) begin
                            shift  <= {din_s, shift[DATA_BITS-1:1]};
                            scount <= '0;
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == BC_LAST)
`ifdef SERIAL_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                        end else begin
                            scount <= scount + 1'b1;
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    PARITY: begin
                        if (scount == SC_LAST) begin
                            par_bit <= din_s;
                            scount  <= '0;
                            state   <= STOP;
                        end else begin
                            scount <= scount + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (scount == SC_LAST) begin
                            scount <= '0;
                            // a low stop bit outranks every other outcome of the frame
                            if (!din_s) begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
`ifdef SERIAL_RX_PARITY_EN
                            end else if (parity_bad(shift, par_bit)) begin
                                parity_err <= 1'b1;
                                state      <= IDLE;
`endif
                            end else begin
                                state <= IDLE;
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end else begin
                            scount <= scount + 1'b1;
                        end
                    end
                    WAIT_IDLE: begin
                        if (din_s)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_rx_controller.sv
// Scoreboard bench for serial_rx_controller: stimulus queues expected events, a monitor pops and compares.
// Define SERIAL_RX_PARITY_EN to also exercise the parity build.
module tb_serial_rx_controller;

    localparam int CLK_DIV = 4;
    localparam int SR      = 16;
    localparam int DB      = 8;
    localparam int BIT     = CLK_DIV * SR;

    localparam logic [1:0] K_BYTE  = 2'd0;
    localparam logic [1:0] K_FRAME = 2'd1;
    localparam logic [1:0] K_OVR   = 2'd2;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [1:0] K_PAR   = 2'd3;
`endif

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          din;
    logic          rx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef SERIAL_RX_PARITY_EN
    logic          parity_err;
`endif

    ev_t  exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    logic v_prev = 1'b0;
    logic saw_busy;

    serial_rx_controller #(
        .CLK_DIV(CLK_DIV),
        .SAMPLE_RATIO(SR),
        .DATA_BITS(DB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_event: got kind %0d data %0h, required no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_data", 32'(data), 32'(e.data));
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                v_prev = 1'b0;
            end else begin
                if (frame_err && overrun)
                    check("err_exclusive", 32'd1, 32'd0);
                if (rx_valid && (!v_prev || rx_ready))
                    got_ev(K_BYTE, rx_data);
                if (frame_err)
                    got_ev(K_FRAME, {7'd0, rx_valid});
                if (overrun)
                    got_ev(K_OVR, rx_data);
`ifdef SERIAL_RX_PARITY_EN
                if (parity_err)
                    got_ev(K_PAR, {7'd0, rx_valid});
`endif
                v_prev = rx_valid;
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        din = b;
        repeat (BIT - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic use_par, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++)
            drive_bit(d[i]);
        if (use_par)
            drive_bit(par);
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        din = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rx_data"},   32'(rx_data),   32'd0);
        check({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_overrun"},   32'(overrun),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin : stimulus
        rst_n    = 1'b0;
        din      = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        idle(20);

        // 0xA5, good stop bit, consumer ready
        expect_ev(K_BYTE, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(8);
        check("a5_busy_after", 32'(busy), 32'd0);
        check("a5_valid_cleared", 32'(rx_valid), 32'd0);

        // 16-clk glitch: START entered, rejected at mid-bit
        saw_busy = 1'b0;
        @(negedge clk);
        din = 1'b0;
        repeat (16) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
        end
        din = 1'b1;
        repeat (60) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
        end
        check("glitch_busy_seen", 32'(saw_busy), 32'd1);
        check("glitch_busy_end", 32'(busy), 32'd0);

        // 0x3C with a low stop bit followed by a break
        expect_ev(K_FRAME, 8'h00);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        check("break_busy_held", 32'(busy), 32'd1);
        idle(12);
        check("break_busy_released", 32'(busy), 32'd0);

        // back-to-back bytes with the consumer stalled
        @(negedge clk);
        rx_ready = 1'b0;
        expect_ev(K_BYTE, 8'h11);
        expect_ev(K_OVR, 8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        idle(8);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
        idle(10);

        // reset in the middle of data bit 4 of 0x5A
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(1'(8'h5A >> i));
        @(negedge clk);
        din = 1'(8'h5A >> 4);
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        din   = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("midreset");
        rst_n = 1'b1;
        idle(128);
        expect_ev(K_BYTE, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle(8);
        check("after_reset_busy", 32'(busy), 32'd0);

`ifdef SERIAL_RX_PARITY_EN
        // even parity: three ones in 0x07 need parity bit 1
        expect_ev(K_BYTE, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(8);
        expect_ev(K_PAR, 8'h00);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(8);
        check("par_no_valid", 32'(rx_valid), 32'd0);
        check("par_err_idle", 32'(parity_err), 32'd0);
`endif

        idle(20);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_mis++;
            $display("FAIL missing_event: got nothing, required kind %0d data %0h", e.kind, e.data);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
